// File: rtl/wb_writeback_unit.sv
// Write-back stage: drives the register-file write port from ALU results, scalar loads,
// and vector loads assembled from LANES sequential memory beats.
module wb_writeback_unit #(
  parameter int LANES  = 8,
  parameter int LANE_W = 32,
  parameter int REG_AW = 5,
  parameter int VEC_W  = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_scalar_we,
  input  logic              in_vector_we,
  input  logic              in_sel_mem,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [LANE_W-1:0] in_alu_scalar,
  input  logic [VEC_W-1:0]  in_alu_vector,
  input  logic [LANE_W-1:0] in_mem_scalar,
  input  logic              mem_beat_valid,
  input  logic [LANE_W-1:0] mem_beat_data,
  output logic              WRITEREGISTER_WB,
  output logic              WRITEREGISTERVEC_WB,
  output logic [REG_AW-1:0] RD_WB,
  output logic [VEC_W-1:0]  INPUTDATA,
  output logic              err,
  output logic              dbg_state
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  // Handshake: an instruction moves from MEM/WB into this stage on a rising edge where
  // in_valid & in_ready are both high; in_ready is high only in IDLE and never depends on in_valid.
  typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [VEC_W-1:0]    buf_q, buf_d;
  logic [REG_AW-1:0]   rd_lat_q, rd_lat_d;
  logic                err_q, err_d;
  logic                wr_s_q, wr_s_d;
  logic                wr_v_q, wr_v_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [VEC_W-1:0]    data_q, data_d;

  assign in_ready            = (state_q == IDLE);
  assign WRITEREGISTER_WB    = wr_s_q;
  assign WRITEREGISTERVEC_WB = wr_v_q;
  assign RD_WB               = rd_q;
  assign INPUTDATA           = data_q;
  assign err                 = err_q;
  assign dbg_state           = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    rd_lat_d = rd_lat_q;
    err_d    = err_q;
    wr_s_d   = 1'b0;
    wr_v_d   = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        // A beat with no vector load in flight has nowhere to go.
        if (mem_beat_valid) err_d = 1'b1;
        if (in_valid) begin
          if (in_vector_we) begin
            if (in_scalar_we) err_d = 1'b1;
            if (in_sel_mem) begin
              rd_lat_d = in_rd;
              buf_d    = '0;
              cnt_d    = '0;
              state_d  = COLLECT;
            end else begin
              wr_v_d = 1'b1;
              rd_d   = in_rd;
              data_d = in_alu_vector;
            end
          end else if (in_scalar_we) begin
            wr_s_d = 1'b1;
            rd_d   = in_rd;
            data_d = '0;
            data_d[LANE_W-1:0] = in_sel_mem ? in_mem_scalar : in_alu_scalar;
          end
        end
      end
      COLLECT: begin
        if (mem_beat_valid) begin
          buf_d[int'(cnt_q)*LANE_W +: LANE_W] = mem_beat_data;
          if (cnt_q == CNT_W'(LANES - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            wr_v_d  = 1'b1;
            rd_d    = rd_lat_q;
            data_d  = buf_d;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      buf_q    <= '0;
      rd_lat_q <= '0;
      err_q    <= 1'b0;
      wr_s_q   <= 1'b0;
      wr_v_q   <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      rd_lat_q <= rd_lat_d;
      err_q    <= err_d;
      wr_s_q   <= wr_s_d;
      wr_v_q   <= wr_v_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Bench for wb_writeback_unit: table-driven single-cycle writes, hand sequences for
// vector-load assembly, back-pressure, reset abort and error flag, plus a write-port scoreboard.
module tb_wb_writeback_unit;

  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int REG_AW = 5;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int W      = 2 + REG_AW + VEC_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_scalar_we;
  logic              in_vector_we;
  logic              in_sel_mem;
  logic [REG_AW-1:0] in_rd;
  logic [LANE_W-1:0] in_alu_scalar;
  logic [VEC_W-1:0]  in_alu_vector;
  logic [LANE_W-1:0] in_mem_scalar;
  logic              mem_beat_valid;
  logic [LANE_W-1:0] mem_beat_data;
  logic              wr_s;
  logic              wr_v;
  logic [REG_AW-1:0] rd_wb;
  logic [VEC_W-1:0]  wdata;
  logic              err;
  logic              dbg_state;

  wb_writeback_unit #(.LANES(LANES), .LANE_W(LANE_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_scalar_we(in_scalar_we), .in_vector_we(in_vector_we), .in_sel_mem(in_sel_mem),
    .in_rd(in_rd), .in_alu_scalar(in_alu_scalar), .in_alu_vector(in_alu_vector),
    .in_mem_scalar(in_mem_scalar),
    .mem_beat_valid(mem_beat_valid), .mem_beat_data(mem_beat_data),
    .WRITEREGISTER_WB(wr_s), .WRITEREGISTERVEC_WB(wr_v), .RD_WB(rd_wb), .INPUTDATA(wdata),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  typedef struct {
    logic              s_we;
    logic              v_we;
    logic              sel;
    logic [REG_AW-1:0] rd;
    logic [LANE_W-1:0] alu_s;
    logic [LANE_W-1:0] mem_s;
    logic [VEC_W-1:0]  alu_v;
    logic              e_s;
    logic              e_v;
    logic [REG_AW-1:0] e_rd;
    logic [VEC_W-1:0]  e_data;
  } vec_t;

  vec_t tbl[6];

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [VEC_W-1:0] ramp(logic [LANE_W-1:0] base);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = base + LANE_W'(i);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_scalar_we = 1'b0; in_vector_we = 1'b0; in_sel_mem = 1'b0;
    in_rd = '0; in_alu_scalar = '0; in_alu_vector = '0; in_mem_scalar = '0;
    mem_beat_valid = 1'b0; mem_beat_data = '0;
  endtask

  task automatic push_exp(logic s, logic v, logic [REG_AW-1:0] rd, logic [VEC_W-1:0] d);
    exp_q.push_back({s, v, rd, d});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("ready_in_reset", W'(in_ready), W'(1));
    tick();
    tick();
    check("reset_outputs", {wr_s, wr_v, rd_wb, wdata}, '0);
    check("reset_err", W'(err), W'(0));
    rst = 1'b1;
    tick();
  endtask

  task automatic start_vload(logic [REG_AW-1:0] rd);
    in_valid = 1'b1; in_scalar_we = 1'b0; in_vector_we = 1'b1; in_sel_mem = 1'b1; in_rd = rd;
    tick();
    in_valid = 1'b0; in_vector_we = 1'b0; in_sel_mem = 1'b0;
    check("collect_entry_ready", W'(in_ready), W'(0));
  endtask

  // Sends n beats starting at lane `first`; optional one-cycle gap after lane `gap_after`.
  task automatic send_beats(logic [LANE_W-1:0] base, int first, int n, int gap_after);
    for (int i = first; i < first + n; i++) begin
      mem_beat_valid = 1'b1;
      mem_beat_data  = base + LANE_W'(i);
      tick();
      mem_beat_valid = 1'b0;
      if (i < LANES - 1) check("collect_ready_low", W'(in_ready), W'(0));
      if (i == gap_after) begin
        tick();
        check("gap_ready_low", W'(in_ready), W'(0));
        check("gap_no_strobe", W'({wr_s, wr_v}), W'(0));
      end
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [VEC_W-1:0] v;
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst = 1'b0;

    tbl[0] = '{1, 0, 0, 5'd3, 32'hDEADBEEF, 32'h0, '0,
               1, 0, 5'd3, {224'b0, 32'hDEADBEEF}};
    tbl[1] = '{0, 1, 0, 5'd7, 32'h0, 32'h0,
               256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001,
               0, 1, 5'd7,
               256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001};
    tbl[2] = '{1, 0, 1, 5'd5, 32'h11111111, 32'hCAFEF00D, '0,
               1, 0, 5'd5, {224'b0, 32'hCAFEF00D}};
    tbl[3] = '{0, 0, 0, 5'd4, 32'h22222222, 32'h33333333, '1,
               0, 0, 5'd5, {224'b0, 32'hCAFEF00D}};
    tbl[4] = '{1, 0, 0, 5'd31, 32'hFFFFFFFF, 32'h0BADF00D, '1,
               1, 0, 5'd31, {224'b0, 32'hFFFFFFFF}};
    tbl[5] = '{0, 1, 0, 5'd0, 32'h5, 32'h6, {8{32'hA5A5_5A5A}},
               0, 1, 5'd0, {8{32'hA5A5_5A5A}}};

    fork
      forever begin
        @(negedge clk);
        if (rst && (wr_s || wr_v)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_write: got s=%0b v=%0b rd=%0d expected no write",
                     wr_s, wr_v, rd_wb);
          end else begin
            check("sb_write", {wr_s, wr_v, rd_wb, wdata}, exp_q.pop_front());
          end
        end
      end
    join_none

    do_reset();

    // Table: back-to-back single-cycle instructions, one per cycle.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_scalar_we = tbl[i].s_we; in_vector_we = tbl[i].v_we; in_sel_mem = tbl[i].sel;
      in_rd = tbl[i].rd; in_alu_scalar = tbl[i].alu_s; in_mem_scalar = tbl[i].mem_s;
      in_alu_vector = tbl[i].alu_v;
      check("tbl_ready", W'(in_ready), W'(1));
      if (tbl[i].e_s || tbl[i].e_v) push_exp(tbl[i].e_s, tbl[i].e_v, tbl[i].e_rd, tbl[i].e_data);
      tick();
      check($sformatf("tbl%0d_write", i), {wr_s, wr_v, rd_wb, wdata},
            {tbl[i].e_s, tbl[i].e_v, tbl[i].e_rd, tbl[i].e_data});
    end
    idle_inputs();
    tick();
    check("strobe_single_pulse", W'({wr_s, wr_v}), W'(0));

    // Vector load with an idle cycle after beat 3.
    v = ramp(32'h10);
    push_exp(1'b0, 1'b1, 5'd2, v);
    start_vload(5'd2);
    send_beats(32'h10, 0, LANES, 3);
    check("vload_write", {wr_s, wr_v, rd_wb, wdata}, {1'b0, 1'b1, 5'd2, v});
    check("vload_ready_back", W'(in_ready), W'(1));
    tick();

    // Scalar held valid during a vector load: accepted only once in_ready returns.
    v = ramp(32'h40);
    push_exp(1'b0, 1'b1, 5'd6, v);
    push_exp(1'b1, 1'b0, 5'd9, {224'b0, 32'h00001234});
    start_vload(5'd6);
    in_valid = 1'b1; in_scalar_we = 1'b1; in_rd = 5'd9; in_alu_scalar = 32'h00001234;
    send_beats(32'h40, 0, LANES, -1);
    check("held_vec_first", {wr_s, wr_v, rd_wb, wdata}, {1'b0, 1'b1, 5'd6, v});
    tick();
    idle_inputs();
    check("held_scalar_next", {wr_s, wr_v, rd_wb, wdata},
          {1'b1, 1'b0, 5'd9, 224'b0, 32'h00001234});
    tick();

    // Reset after 4 beats: aborted load writes nothing, next load is clean.
    start_vload(5'd11);
    send_beats(32'h30, 0, 4, -1);
    rst = 1'b0;
    #1;
    check("abort_state_idle", W'({in_ready, dbg_state}), W'(2'b10));
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_no_strobe", W'({wr_s, wr_v}), W'(0));
    v = ramp(32'h20);
    push_exp(1'b0, 1'b1, 5'd13, v);
    start_vload(5'd13);
    send_beats(32'h20, 0, LANES, -1);
    check("fresh_vload", {wr_s, wr_v, rd_wb, wdata}, {1'b0, 1'b1, 5'd13, v});
    check("err_clear_after_loads", W'(err), W'(0));
    tick();

    // Stray beat in IDLE, then both write enables set.
    mem_beat_valid = 1'b1; mem_beat_data = 32'hFFFF0000;
    tick();
    mem_beat_valid = 1'b0;
    check("stray_beat_err", W'({err, wr_s, wr_v, in_ready}), W'(4'b1001));
    tick();
    check("err_sticky", W'(err), W'(1));
    do_reset();
    check("err_reset_clear", W'(err), W'(0));
    v = {8{32'h0F0F_1234}};
    push_exp(1'b0, 1'b1, 5'd12, v);
    in_valid = 1'b1; in_scalar_we = 1'b1; in_vector_we = 1'b1; in_sel_mem = 1'b0;
    in_rd = 5'd12; in_alu_vector = v; in_alu_scalar = 32'h77777777;
    tick();
    idle_inputs();
    check("both_we_vec_only", {wr_s, wr_v, rd_wb, wdata}, {1'b0, 1'b1, 5'd12, v});
    check("both_we_err", W'(err), W'(1));
    tick();
    tick();
    check("both_we_err_sticky", W'(err), W'(1));
    do_reset();

    tick();
    check("sb_drained", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
